uart_tx_sched: RTL
==================

// Module: uart_tx_sched
// PURPOSE
// - Shares one UART transmitter (8N1, flag_in/data_in byte-launch interface) among N_REQ byte sources.
// - Arbitrates round-robin, launches one byte per frame, then times the frame internally:
//   the transmitter exposes no busy signal.
// - Sits between application byte sources and the UART transmitter, in the same clock domain.
// PARAMETERS
// - CLK        50000000  system clock frequency, Hz
// - BAUD       115200    line rate, bit/s
// - N_REQ      4         number of requesters, range 2..8
// - FRAME_BITS 10        bits per frame (start + 8 data + stop)
// - GUARD_CYC  2         extra idle clocks appended after each frame
// PORTS
// - clk       in   1         system clock
// - rstn      in   1         reset, synchronous, active-low
// - req       in   N_REQ     req[i]=1: requester i has a byte pending
// - req_data  in   8*N_REQ   byte of requester i at [8*i+7:8*i]
// - ack       out  N_REQ     one-cycle pulse: byte of requester i taken
// - data_out  out  8         to transmitter data_in
// - flag_out  out  1         to transmitter flag_in; one-cycle launch pulse
// - busy      out  1         1 while a frame is launching or in flight
// - grant_id  out  3         index of the last granted requester
// BEHAVIOUR
// - Reset values: ack=0, data_out=8'h00, flag_out=0, busy=0, grant_id=0, rr pointer=0, state=IDLE.
// - Frame length: FRAME_CYC = (CLK/BAUD)*FRAME_BITS + GUARD_CYC, with CLK/BAUD as integer division.
//   Defaults: 434*10+2 = 4342 clocks.
// - Counter width: $clog2(FRAME_CYC+1).
// - States: IDLE -> LAUNCH -> WAIT -> IDLE.
// - IDLE: if |req is 1 at an edge, select winner w. data_out<=req_data[w], grant_id<=w, go LAUNCH.
//   Otherwise stay; busy=0.
// - LAUNCH (exactly 1 cycle): flag_out=1, ack[w]=1, busy=1. Load counter = FRAME_CYC-1. Go WAIT.
// - WAIT: busy=1; counter decrements each clock; at counter==0 go IDLE.
//   data_out holds its value through LAUNCH and WAIT.
// - Latency: req sampled in IDLE at edge t -> flag_out/ack high during cycle t+1.
// - Back-to-back: next flag_out comes exactly FRAME_CYC+1 clocks after the previous one
//   (one IDLE cycle for arbitration).
// - Round-robin: search starts at pointer p, wrapping modulo N_REQ. After a grant, p <= w+1
//   (wraps N_REQ-1 -> 0).
// - Handshake: a requester holds req and req_data stable until its ack.
//   - req deasserted before grant: allowed, ignored.
//   - req/req_data changes during LAUNCH/WAIT: ignored.
// - Requester i still asserting req after ack[i]: treated as a new byte. It competes at the next IDLE.
// - Simultaneous requests: exactly one ack per frame; ack is never multi-hot.
// - Reset mid-frame: rstn=0 at any edge forces all reset values next cycle, abandoning the frame.
//   The transmitter shares rstn.
// - req bits at index >= N_REQ do not exist; grant_id is zero-extended to 3 bits.
// CONFIGURATION
// - UART_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins.
//   The rr pointer is removed, and req[0] can starve the others.
// - Undefined (default): round-robin as above.
// TESTING (bench params: CLK=1000, BAUD=100, N_REQ=4, GUARD_CYC=2 -> FRAME_CYC=102)
// - Reset: hold rstn=0 for 3 cycles with req=4'hF.
//   -> ack=0, flag_out=0, busy=0, data_out=00, grant_id=0.
// - Single: req=4'b0100, byte 2=8'hA5.
//   -> next cycle flag_out=1, ack=4'b0100, data_out=A5; busy high 102 cycles; then busy=0.
// - RR fairness: req=4'hF held, bytes 11/22/33/44.
//   -> grants 0,1,2,3,0 in that order; flag_out pulses exactly 103 cycles apart.
// - Sparse wrap: p=3 after grant 2; req=4'b0011 -> grant 0, then 1.
// - Mid-frame reset: rstn=0 at WAIT count 50 -> busy=0 next cycle.
//   After release with req=4'b1000: grant 3, pointer starts at 0.
// - FIXED_PRIO_EN: req=4'hF held -> every grant is 0.
//   Drop req[0] -> grant 1 on the next frame.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Byte-source / transmitter-side signal bundle for uart_tx_sched.
// The master modport is the scheduler; slave is the requester/transmitter side.
interface uart_tx_sched_if #(
   parameter int N_REQ = 4
) ();
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   ack;
   logic [7:0]         data_out;
   logic               flag_out;
   logic               busy;
   logic [2:0]         grant_id;

   modport master (
      input  req, req_data,
      output ack, data_out, flag_out, busy, grant_id
   );

   modport slave (
      output req, req_data,
      input  ack, data_out, flag_out, busy, grant_id
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one busy-less 8N1 UART transmitter among N_REQ byte sources.
// Define UART_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module uart_tx_sched #(
   parameter int CLK        = 50000000,
   parameter int BAUD       = 115200,
   parameter int N_REQ      = 4,
   parameter int FRAME_BITS = 10,
   parameter int GUARD_CYC  = 2
) (
   input  logic            clk,
   input  logic            rstn,
   uart_tx_sched_if.master bus
);
   localparam int FRAME_CYC = (CLK / BAUD) * FRAME_BITS + GUARD_CYC;
   localparam int CW        = $clog2(FRAME_CYC + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [7:0]       data_q, data_d;
   logic             flag_q, flag_d;
   logic             busy_q, busy_d;
   logic [2:0]       gid_q, gid_d;
`ifndef UART_SCHED_FIXED_PRIO_EN
   logic [2:0]       ptr_q, ptr_d;
`endif

   logic [7:0]       req_s;
   logic [63:0]      rdat_s;
   logic [7:0]       onehot_s;
   logic [2:0]       win_s;
   logic             hit_s;

   // Zero-pad request lanes to 8 so lanes >= N_REQ read as absent
   always_comb begin
      req_s                  = 8'd0;
      req_s[N_REQ-1:0]       = bus.req;
      rdat_s                 = 64'd0;
      rdat_s[8*N_REQ-1:0]    = bus.req_data;
      onehot_s               = 8'd1 << win_s;
   end

   // Winner search: first pending lane starting at the pointer (or at lane 0)
   always_comb begin
      logic [3:0] raw;
      logic [2:0] idx;
      logic       take;
      win_s = 3'd0;
      hit_s = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_SCHED_FIXED_PRIO_EN
         raw = 4'(k);
`else
         raw = {1'b0, ptr_q} + 4'(k);
`endif
         idx   = (raw >= 4'(N_REQ)) ? 3'(raw - 4'(N_REQ)) : raw[2:0];
         take  = !hit_s && req_s[idx];
         win_s = take ? idx : win_s;
         hit_s = hit_s | take;
      end
   end

   // Frame sequencer; counter holds FRAME_CYC-1 during LAUNCH so LAUNCH+WAIT spans FRAME_CYC clocks
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = {N_REQ{1'b0}};
      data_d  = data_q;
      flag_d  = 1'b0;
      busy_d  = busy_q;
      gid_d   = gid_q;
`ifndef UART_SCHED_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (hit_s) begin
               data_d  = rdat_s[{win_s, 3'b000} +: 8];
               gid_d   = win_s;
               ack_d   = onehot_s[N_REQ-1:0];
               flag_d  = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = CW'(FRAME_CYC - 1);
               state_d = S_LAUNCH;
`ifndef UART_SCHED_FIXED_PRIO_EN
               ptr_d   = (win_s == 3'(N_REQ - 1)) ? 3'd0 : win_s + 3'd1;
`endif
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_LAUNCH: begin
            cnt_d   = cnt_q - CW'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CW'(0)) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= CW'(0);
         ack_q   <= {N_REQ{1'b0}};
         data_q  <= 8'h00;
         flag_q  <= 1'b0;
         busy_q  <= 1'b0;
         gid_q   <= 3'd0;
`ifndef UART_SCHED_FIXED_PRIO_EN
         ptr_q   <= 3'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         busy_q  <= busy_d;
         gid_q   <= gid_d;
`ifndef UART_SCHED_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign bus.ack      = ack_q;
   assign bus.data_out = data_q;
   assign bus.flag_out = flag_q;
   assign bus.busy     = busy_q;
   assign bus.grant_id = gid_q;
endmodule
